// File: rtl/mem_responder.sv
// Word-addressed load/store responder with fixed access latency and byte-enabled stores.
// One transaction in flight at a time: accept, wait LATENCY cycles, respond, repeat.
module mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT        = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        req_write_p0;
    logic [31:0] req_addr_p0;
    logic [31:0] req_wdata_p0;
    logic [3:0]  req_be_p0;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, rsp_done, enter_resp, is_idle;
    logic        acc_write, acc_error;
    logic [31:0] acc_addr, acc_wdata, acc_offset;
    logic [3:0]  acc_be;
    logic [AW-1:0] acc_index;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) result[8*b +: 8] = new_word[8*b +: 8];
        end
        return result;
    endfunction

    // Addresses below BASE_ADDR wrap to huge offsets and fail the span test too.
    function automatic logic addr_error(input logic [31:0] addr, input logic [31:0] offset);
        return (addr[1:0] != 2'b00) || (offset >= SPAN_BYTES);
    endfunction

    assign is_idle    = (state == S_IDLE);
    assign accept     = req_valid_i & req_ready_o;
    assign rsp_done   = rsp_valid_o & rsp_ready_i;
    assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);

    // With zero latency the access happens on the acceptance edge, so use the live request.
    assign acc_write  = is_idle ? req_write_i : req_write_p0;
    assign acc_addr   = is_idle ? req_addr_i  : req_addr_p0;
    assign acc_wdata  = is_idle ? req_wdata_i : req_wdata_p0;
    assign acc_be     = is_idle ? req_be_i    : req_be_p0;
    assign acc_offset = acc_addr - BASE_ADDR;
    assign acc_index  = acc_offset[AW+1:2];
    assign acc_error  = addr_error(acc_addr, acc_offset);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = (LAT == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
            S_RESP:  if (rsp_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = is_idle;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (is_idle && accept) begin
            cnt <= LAT;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Request holding stage
    always_ff @(posedge clock) begin
        if (accept) begin
            req_write_p0 <= req_write_i;
            req_addr_p0  <= req_addr_i;
            req_wdata_p0 <= req_wdata_i;
            req_be_p0    <= req_be_i;
        end
    end

    // Access / response stage
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_error_o <= 1'b0;
        end else if (enter_resp) begin
            rsp_valid_o <= 1'b1;
            rsp_error_o <= acc_error;
            rsp_rdata_o <= (acc_write || acc_error) ? 32'h0 : mem[acc_index];
        end else if (rsp_done) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_error_o <= 1'b0;
        end
    end

    // A store still in flight when reset arrives never reaches the array.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && acc_write && !acc_error) begin
            mem[acc_index] <= merge_bytes(mem[acc_index], acc_wdata, acc_be);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2/BASE=0/256 words and
// LATENCY=0/BASE=0x1000/16 words) checked against an array-based memory model.
`timescale 1ns/1ps
module tb_mem_responder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc [2];
    logic [31:0] model [2][256];

    always @(posedge clock) cyc <= cyc + 1;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_error_o(rsp_error[0]));

    mem_responder #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDR(32'h0000_1000)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_error_o(rsp_error[1]));

    function automatic int dep(input int d);
        return (d == 0) ? 256 : 16;
    endfunction
    function automatic logic [31:0] basea(input int d);
        return (d == 0) ? 32'h0 : 32'h1000;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Reference: an address is bad if unaligned, below the base, or past the last word.
    function automatic logic m_err(input int d, input logic [31:0] a);
        return (a % 4 != 0) || (a < basea(d)) || ((a - basea(d)) / 4 >= 32'(dep(d)));
    endfunction

    task automatic model_txn(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             output logic [31:0] exp_rd, output logic exp_er);
        int idx;
        exp_er = m_err(d, a);
        exp_rd = 32'h0;
        if (!exp_er) begin
            idx = int'((a - basea(d)) / 4);
            if (!w) exp_rd = model[d][idx];
            else for (int b = 0; b < 4; b++)
                if (be[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        int r, k;
        r = $urandom_range(0, 9);
        k = $urandom_range(0, dep(d) - 1);
        if (r < 7)       return basea(d) + 32'(4 * k);
        else if (r == 7) return basea(d) + 32'(4 * k + $urandom_range(1, 3));
        else if (r == 8) return basea(d) + 32'(dep(d) * 4 + 4 * k);
        else             return basea(d) - 32'(4 * (k + 1));
    endfunction

    // Drives one request, waits for its response and completes the handshake.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat, output logic rdy_after, output logic vld_after);
        int t;
        req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
        t = 0;
        while (!req_ready[d] && t < 50) begin @(posedge clock); #1; t++; end
        @(posedge clock); #1;
        acc_cyc[d] = cyc;
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
        req_be[d] = 4'($urandom);
        lat = 1;
        while (!rsp_valid[d] && lat < 50) begin @(posedge clock); #1; lat++; end
        rd = rsp_rdata[d]; er = rsp_error[d];
        rsp_ready[d] = 1'b1;
        @(posedge clock); #1;
        rsp_ready[d] = (d == 1);
        rdy_after = req_ready[d]; vld_after = rsp_valid[d];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready d=%0d got %b want 1", d, req_ready[d]); end
            checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid d=%0d got %b want 0", d, rsp_valid[d]); end
            checks++; if (rsp_rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata d=%0d got %h want 0", d, rsp_rdata[d]); end
            checks++; if (rsp_error[d] !== 1'b0) begin errors++; $display("FAIL reset_error d=%0d got %b want 0", d, rsp_error[d]); end
        end
    endtask

    task automatic test_init_mem(input int d);
        logic [31:0] rd, erd, wd; logic er, eer, ra, va; int lat;
        for (int i = 0; i < dep(d); i++) begin
            wd = $urandom;
            model_txn(d, 1'b1, basea(d) + 32'(4 * i), wd, 4'hF, erd, eer);
            txn(d, 1'b1, basea(d) + 32'(4 * i), wd, 4'hF, rd, er, lat, ra, va);
            checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL init_store d=%0d i=%0d got er=%b rd=%h want er=0 rd=0", d, i, er, rd); end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, erd; logic er, eer, ra, va; int lat;
        model_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, ra, va);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_rsp got er=%b rd=%h want er=0 rd=0", er, rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
        model_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, va);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_after_store got rd=%h er=%b want deadbeef 0", rd, er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
        checks++; if (ra !== 1'b1 || va !== 1'b0) begin errors++; $display("FAIL post_handshake got ready=%b valid=%b want 1 0", ra, va); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd, erd; logic er, eer, ra, va; int lat;
        model_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, ra, va);
        model_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, eer);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, ra, va);
        model_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, erd, eer);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, ra, va);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_zero_error got %b want 0", er); end
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, ra, va);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge got %h want 11bb33dd", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd, prior; logic er, eer, ra, va; int lat;
        txn(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat, ra, va);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_load got er=%b rd=%h want 1 0", er, rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL error_latency got %0d want 3", lat); end
        prior = model[0][255];
        model_txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, erd, eer);
        txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, rd, er, lat, ra, va);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL out_of_range_store got er=%b want 1", er); end
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat, ra, va);
        checks++; if (rd !== prior || er !== 1'b0) begin errors++; $display("FAIL last_word_unchanged got rd=%h er=%b want %h 0", rd, er, prior); end
        txn(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, rd, er, lat, ra, va);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL below_base got er=%b rd=%h want 1 0", er, rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd; logic er, eer, ra, va; int lat, t;
        model_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0;
        t = 0;
        while (!req_ready[0] && t < 50) begin @(posedge clock); #1; t++; end
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 50) begin @(posedge clock); #1; t++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== erd || req_ready[0] !== 1'b0)
                begin errors++; $display("FAIL bp_hold i=%0d got v=%b rd=%h rdy=%b want 1 %h 0", i, rsp_valid[0], rsp_rdata[0], req_ready[0], erd); end
            if (i == 1) begin
                req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10;
                req_wdata[0] = 32'hBAD0BAD0; req_be[0] = 4'hF;
            end
            if (i == 2) req_valid[0] = 1'b0;
            @(posedge clock); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clock); #1;
        rsp_ready[0] = 1'b0;
        checks++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b want 0 1", rsp_valid[0], req_ready[0]); end
        repeat (4) @(posedge clock); #1;
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_no_extra_rsp got v=%b want 0", rsp_valid[0]); end
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, va);
        checks++; if (rd !== model[0][4]) begin errors++; $display("FAIL bp_ignored_store got %h want %h", rd, model[0][4]); end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] a, wd, rd, erd; logic [3:0] be; logic w, er, eer, ra, va; int lat;
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom); a = rand_addr(d); wd = $urandom; be = 4'($urandom);
            model_txn(d, w, a, wd, be, erd, eer);
            txn(d, w, a, wd, be, rd, er, lat, ra, va);
            checks++; if (rd !== erd || er !== eer || lat !== lat_of(d) + 1 || ra !== 1'b1 || va !== 1'b0)
                begin errors++; $display("FAIL random d=%0d i=%0d w=%b a=%h got rd=%h er=%b lat=%0d want rd=%h er=%b lat=%0d",
                                         d, i, w, a, rd, er, lat, erd, eer, lat_of(d) + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd, a; logic er, eer, ra, va; int lat, prev;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000 + 32'(4 * i);
            model_txn(1, 1'b0, a, 32'h0, 4'h0, erd, eer);
            txn(1, 1'b0, a, 32'h0, 4'h0, rd, er, lat, ra, va);
            checks++; if (rd !== erd || lat !== 1) begin errors++; $display("FAIL b2b_data i=%0d got rd=%h lat=%0d want %h 1", i, rd, lat, erd); end
            if (prev >= 0) begin
                checks++; if (acc_cyc[1] - prev !== 2) begin errors++; $display("FAIL b2b_period i=%0d got %0d want 2", i, acc_cyc[1] - prev); end
            end
            prev = acc_cyc[1];
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd, erd; logic er, eer, ra, va; int lat, t;
        model_txn(0, 1'b1, 32'h8, 32'h0, 4'hF, erd, eer);
        txn(0, 1'b1, 32'h8, 32'h0, 4'hF, rd, er, lat, ra, va);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h8;
        req_wdata[0] = 32'h55; req_be[0] = 4'hF;
        t = 0;
        while (!req_ready[0] && t < 50) begin @(posedge clock); #1; t++; end
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0)
            begin errors++; $display("FAIL midflight_reset got rdy=%b v=%b rd=%h want 1 0 0", req_ready[0], rsp_valid[0], rsp_rdata[0]); end
        repeat (3) @(posedge clock); #1;
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat, ra, va);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midflight_store_dropped got %h want 0", rd); end
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, va);
        checks++; if (rd !== model[0][4]) begin errors++; $display("FAIL mem_survives_reset got %h want %h", rd, model[0][4]); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'h0;
            req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = (d == 1);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_init_mem(0);
        test_init_mem(1);
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_random(0, 80);
        test_random(1, 60);
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
